// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared state encoding, unit counts and frame word builder for the NEC transmitter
package nec_ir_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_RPT_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } nec_state_t;
  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int RPT_SPACE_U  = 4;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;
  function automatic logic [31:0] nec_word(input logic [15:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, addr};
  endfunction
endpackage

// File: rtl/nec_carrier_gen.sv
// nec_carrier_gen: 38 kHz carrier toggle, restartable at phase 1, idle low when disabled
module nec_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iEN,
  input  logic iRESTART,
  output logic oCARRIER
);
  localparam int CW = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt      <= '0;
      oCARRIER <= 1'b0;
    end else if (iRESTART) begin
      cnt      <= '0;
      oCARRIER <= 1'b1;
    end else if (!iEN) begin
      cnt      <= '0;
      oCARRIER <= 1'b0;
    end else if (cnt == CW'(CARRIER_HALF - 1)) begin
      cnt      <= '0;
      oCARRIER <= ~oCARRIER;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC frame / repeat-code IR transmitter with 38 kHz modulated LED drive
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 72
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iVALID,
  output logic        oREADY,
  input  logic        iREPEAT,
  input  logic [15:0] iADDR,
  input  logic [7:0]  iCMD,
  output logic        oIRDA_TX,
  output logic        oENV,
  output logic        oBUSY
);
  localparam int UW = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
  localparam int NW = $clog2((GAP_UNITS > LEAD_MARK_U ? GAP_UNITS : LEAD_MARK_U) + 1);
  nec_state_t    state, state_n;
  logic [UW-1:0] ucnt;
  logic [NW-1:0] ncnt, dur;
  logic [4:0]    bcnt;
  logic [31:0]   word;
  logic          rpt, accept, unit_end, last, mark, mark_n, restart, carrier;
  assign accept   = iVALID & oREADY;
  assign unit_end = ucnt == UW'(UNIT_CYCLES - 1);
  assign dur = state == S_LEAD_MARK  ? NW'(LEAD_MARK_U)  :
               state == S_LEAD_SPACE ? NW'(LEAD_SPACE_U) :
               state == S_RPT_SPACE  ? NW'(RPT_SPACE_U)  :
               state == S_BIT_MARK   ? NW'(BIT_MARK_U)   :
               state == S_BIT_SPACE  ? (word[bcnt] ? NW'(ONE_SPACE_U) : NW'(ZERO_SPACE_U)) :
               state == S_GAP        ? NW'(GAP_UNITS)    : NW'(STOP_U);
  assign last = unit_end && ncnt == dur - 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       if (accept) state_n = S_LEAD_MARK;
      S_LEAD_MARK:  if (last) state_n = rpt ? S_RPT_SPACE : S_LEAD_SPACE;
      S_LEAD_SPACE: if (last) state_n = S_BIT_MARK;
      S_RPT_SPACE:  if (last) state_n = S_STOP_MARK;
      S_BIT_MARK:   if (last) state_n = S_BIT_SPACE;
      S_BIT_SPACE:  if (last) state_n = &bcnt ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (last) state_n = S_GAP;
      S_GAP:        if (last) state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ucnt <= '0;
      ncnt <= '0;
      bcnt <= '0;
      word <= '0;
      rpt  <= 1'b0;
    end else begin
      if (accept) begin
        word <= nec_word(iADDR, iCMD);
        rpt  <= iREPEAT;
        bcnt <= '0;
      end else if (state == S_BIT_SPACE && last) begin
        bcnt <= bcnt + 1'b1;
      end
      ucnt <= (state == S_IDLE || unit_end) ? '0 : ucnt + 1'b1;
      ncnt <= (state_n != state) ? '0 : unit_end ? ncnt + 1'b1 : ncnt;
    end
  end
  assign mark    = state == S_LEAD_MARK || state == S_BIT_MARK || state == S_STOP_MARK;
  assign mark_n  = state_n == S_LEAD_MARK || state_n == S_BIT_MARK || state_n == S_STOP_MARK;
  assign restart = mark_n && state_n != state;
  nec_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .iEN      (mark),
    .iRESTART (restart),
    .oCARRIER (carrier)
  );
  assign oENV     = mark;
  assign oIRDA_TX = carrier & mark;
  assign oREADY   = state == S_IDLE;
  assign oBUSY    = state != S_IDLE;
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: randomized scoreboard bench comparing observed envelope runs with NEC timing rules
module tb_nec_ir_tx;
  localparam int U = 4;
  localparam int G = 8;
  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic        iVALID = 1'b0;
  logic        iREPEAT = 1'b0;
  logic [15:0] iADDR = '0;
  logic [7:0]  iCMD = '0;
  logic        oREADY, oIRDA_TX, oENV, oBUSY;
  int total = 0;
  int bad = 0;
  nec_ir_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(1), .GAP_UNITS(G)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iVALID(iVALID), .oREADY(oREADY), .iREPEAT(iREPEAT),
    .iADDR(iADDR), .iCMD(iCMD), .oIRDA_TX(oIRDA_TX), .oENV(oENV), .oBUSY(oBUSY)
  );
  always #5 iCLK = ~iCLK;
  logic [31:0] exp_word_q[$];
  bit          exp_rpt_q[$];
  int          runs[$];
  bit          in_txn = 0, cont = 0, cont_close = 0;
  int          cur_len = 0, idle_len = 0;
  logic        cur_env = 0, prev_env = 0, ph = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int exp_len(input bit r);
    return r ? 4 : 68;
  endfunction
  // alternating mark/space run lengths in cycles, starting with the leader mark and ending with the gap
  function automatic int exp_run(input logic [31:0] w, input bit r, input int i);
    if (r) return i == 0 ? 16 * U : i == 1 ? 4 * U : i == 2 ? U : G * U;
    if (i == 0) return 16 * U;
    if (i == 1) return 8 * U;
    if (i == 66) return U;
    if (i == 67) return G * U;
    return (i % 2 == 0) ? U : (w[(i - 2) / 2] ? 3 * U : U);
  endfunction
  always @(posedge iCLK)
    if (iRST_n && iVALID && oREADY) begin
      exp_word_q.push_back({~iCMD, iCMD, iADDR});
      exp_rpt_q.push_back(iREPEAT);
    end
  task automatic close_txn();
    logic [31:0] w, dw;
    bit r;
    int n;
    runs.push_back(cur_len);
    chk("txn_expected", exp_word_q.size() > 0, 1);
    if (exp_word_q.size() == 0) return;
    w = exp_word_q.pop_front();
    r = exp_rpt_q.pop_front();
    n = exp_len(r);
    chk("run_count", runs.size(), n);
    for (int i = 0; i < n && i < runs.size(); i++) chk($sformatf("run%0d", i), runs[i], exp_run(w, r, i));
    if (!r && runs.size() == n) begin
      dw = '0;
      for (int b = 0; b < 32; b++) dw[b] = runs[3 + 2 * b] > 2 * U;
      chk("decoded_word", dw, w);
    end
  endtask
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      if (in_txn) begin
        void'(exp_word_q.pop_front());
        void'(exp_rpt_q.pop_front());
        in_txn = 0;
      end
      chk("rst_env", oENV, 0);
      chk("rst_tx", oIRDA_TX, 0);
      prev_env = 0;
    end else begin
      chk("busy_vs_ready", oBUSY, !oREADY);
      if (oENV) begin
        ph = prev_env ? ~ph : 1'b1;
        chk("carrier_phase", oIRDA_TX, ph);
      end else begin
        chk("tx_in_space", oIRDA_TX, 0);
      end
      prev_env = oENV;
      if (!oREADY) begin
        if (!in_txn) begin
          in_txn = 1;
          runs.delete();
          cur_env = oENV;
          cur_len = 1;
          chk("first_cycle_env", oENV, 1);
          if (cont && cont_close) chk("idle_between", idle_len, 1);
        end else if (oENV == cur_env) begin
          cur_len++;
        end else begin
          runs.push_back(cur_len);
          cur_env = oENV;
          cur_len = 1;
        end
      end else begin
        if (in_txn) begin
          close_txn();
          in_txn = 0;
          cont_close = cont;
          idle_len = 0;
        end
        idle_len++;
      end
    end
  end
  task automatic wait_ready(input int budget);
    int c;
    c = 0;
    while (!(oREADY && !in_txn) && c < budget) begin
      @(negedge iCLK);
      #1;
      c++;
    end
    if (c >= budget) chk("ready_timeout", {31'b0, oREADY & !in_txn}, 1);
  endtask
  task automatic send(input logic [15:0] a, input logic [7:0] c, input bit r);
    wait_ready(2000);
    iADDR = a;
    iCMD = c;
    iREPEAT = r;
    iVALID = 1'b1;
    @(negedge iCLK);
    #1;
    iVALID = 1'b0;
    iADDR = 16'($urandom);
    iCMD = 8'($urandom);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int f, c;
    logic pe;
    #1 iRST_n = 1'b0;
    repeat (3) @(negedge iCLK);
    #1 iRST_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      #1;
      chk("idle_ready", oREADY, 1);
      chk("idle_busy", oBUSY, 0);
      chk("idle_tx", oIRDA_TX, 0);
    end
    send(16'h00FF, 8'h02, 1'b0);
    wait_ready(2000);
    send(16'($urandom), 8'($urandom), 1'b1);
    wait_ready(2000);
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      wait_ready(2000);
    end
    cont = 1;
    iVALID = 1'b1;
    for (int i = 0; i < 1800; i++) begin
      iADDR = 16'($urandom);
      iCMD = 8'($urandom);
      iREPEAT = ($urandom_range(0, 3) == 0);
      @(negedge iCLK);
      #1;
    end
    iVALID = 1'b0;
    cont = 0;
    wait_ready(2000);
    send(16'($urandom), 8'($urandom), 1'b0);
    f = 0;
    c = 0;
    pe = 1'b0;
    while (f < 12 && c < 3000) begin
      @(negedge iCLK);
      #1;
      if (pe && !oENV) f++;
      pe = oENV;
      c++;
    end
    chk("reach_bit10_space", f, 12);
    #2 iRST_n = 1'b0;
    #1;
    chk("async_rst_env", oENV, 0);
    chk("async_rst_tx", oIRDA_TX, 0);
    chk("async_rst_ready", oREADY, 1);
    chk("async_rst_busy", oBUSY, 0);
    repeat (2) @(negedge iCLK);
    #1 iRST_n = 1'b1;
    chk("post_rst_ready", oREADY, 1);
    send(16'($urandom), 8'($urandom), 1'b0);
    wait_ready(2000);
    send(16'hA55A, 8'hFF, 1'b0);
    wait_ready(2000);
    repeat (5) @(negedge iCLK);
    #1;
    chk("queue_drained", exp_word_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
